tinyqv_instr_aligner: RTL and testbench
=======================================

// Module: tinyqv_instr_aligner
// PURPOSE
//  Instruction prefetch/alignment buffer directly upstream of the TinyQV decoder.
//  Accepts a stream of 16-bit halfwords from the fetch/memory interface and stores them in a small circular buffer.
//  Presents a 32-bit instruction window (head halfword in [15:0]) with its PC to the decoder.
//  Pops 1 or 2 halfwords per retired instruction (decoder instr_len); handles redirects (jump/branch/trap) by flushing.
// PARAMETERS
//  BUF_HW   4   buffer depth in halfwords; power of 2, >=2
//  PC_BITS  23  halfword-address width (byte address = {pc, 1'b0}); 24-bit byte space
// PORTS
//  clk             in   1        system clock
//  rstn            in   1        async active-low reset
//  fetch_data      in   16       halfword from memory
//  fetch_valid     in   1        fetch_data valid this cycle
//  fetch_ready     out  1        buffer can accept a halfword this cycle
//  fetch_addr      out  PC_BITS  halfword address of next halfword to fetch
//  fetch_restart   out  1        1-cycle pulse: memory must restart streaming from fetch_addr
//  redirect        in   1        flush and restart at redirect_pc
//  redirect_pc     in   PC_BITS  new halfword PC
//  instr           out  32       instruction window to decoder
//  instr_pc        out  PC_BITS  halfword PC of instr
//  instr_valid     out  1        instr holds a complete instruction
//  instr_consume   in   1        decoder/core retires instr this cycle
//  consume_len     in   2        halfwords to pop (decoder instr_len: 2'b01 or 2'b10)
// BEHAVIOUR
//  Reset: count=0, head=tail=0, instr_pc=0, fetch_addr=0, fetch_restart=1 (first cycle after reset requests addr 0),
//   instr_valid=0, instr=32'h0, fetch_ready=1.
//  Storage: BUF_HW x 16 circular buffer; head/tail log2(BUF_HW) bits, wrap naturally; count 0..BUF_HW.
//  Push: fetch_valid && fetch_ready && !redirect && !fetch_restart -> write at tail, tail++, fetch_addr++ (mod 2^PC_BITS).
//  fetch_ready = (count != BUF_HW); no same-cycle pop credit (registered-count decision only).
//  Window: instr[15:0]=buf[head]; instr[31:16]=buf[head+1] when count>=2, else 16'h0000 (never X).
//  instr_valid = (count>=2) || (count==1 && buf[head][1:0]!=2'b11). Combinational from regs; push in cycle N visible N+1.
//  Pop: instr_consume && instr_valid -> head+=consume_len, count-=consume_len, instr_pc+=consume_len (wraps).
//   Consume while !instr_valid, or consume_len>count, is ignored (no state change); bench asserts it never occurs.
//  Simultaneous push+pop: count_next = count + push - pop_len; both pointers update same cycle.
//  Redirect (highest priority): count=0, head=tail=0, instr_pc=fetch_addr=redirect_pc, fetch_restart=1 next cycle;
//   same-cycle fetch_valid and instr_consume discarded. Redirect during fetch_restart cycle re-arms restart.
//  fetch_restart cycle: fetch_valid ignored; memory delivers new-stream data from the following cycle.
//  Odd/unaligned-to-word redirect_pc fully supported (halfword granularity); 32-bit instr may straddle wrap point.
//  Async reset mid-stream: all state to reset values immediately, independent of clk.
// STRUCTURE
//  Shared header tinyqv_defs.vh: TQV_PC_BITS, TQV_RVC_OPCODE_32 (2'b11), instr-length encodings 2'b01/2'b10.
//  One sub-module: tinyqv_halfword_fifo (circular storage, pointers, count, dual-entry read port, pop of 1 or 2).
//  Top adds PC/fetch_addr tracking, redirect/restart control and instr_valid length check.
// TESTING
//  Reset then push 16'h4501,16'h0513 from 0 -> instr=32'h05134501, instr_valid=1 after 1st push (RVC), instr_pc=0.
//  Push 16'h0513 only (low bits 11) -> instr_valid=0; push 16'h0010 -> instr=32'h00100513 valid; consume len 2 -> pc=2, count=0.
//  Fill 4 halfwords -> fetch_ready=0, further fetch_valid dropped; consume len1 -> fetch_ready=1 next cycle, fetch_addr=4.
//  Wrap: stream 6 halfwords with 32-bit instr starting at buffer index 3 -> instr built from buf[3],buf[0] correctly.
//  redirect_pc=23'h000101 with fetch_valid+consume same cycle -> count=0, instr_valid=0, fetch_restart=1 next cycle,
//   fetch_addr=instr_pc=23'h000101, restart-cycle data discarded.
//  Assert rstn low mid-stream (count=3) -> outputs at reset values asynchronously; resume cleanly from addr 0.

Source files
------------

// File: rtl/tinyqv_instr_aligner_pkg.sv
// Shared constants and types for the TinyQV instruction aligner: PC width,
// RV32 length encodings and the decoder instruction window layout.
package tinyqv_instr_aligner_pkg;

  localparam int unsigned TQV_PC_BITS       = 23;
  localparam logic [1:0]  TQV_RVC_OPCODE_32 = 2'b11;
  localparam logic [1:0]  TQV_LEN_16        = 2'b01;
  localparam logic [1:0]  TQV_LEN_32        = 2'b10;

  // Decoder window: head halfword in the low half.
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } instr_win_t;

endpackage

// File: rtl/tinyqv_halfword_fifo.sv
// Circular halfword buffer with a two-entry read port at the head and a
// pop of one or two entries per cycle.
module tinyqv_halfword_fifo #(
  parameter int unsigned BUF_HW = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  logic [15:0]               i_data,
  input  logic                      i_pop,
  input  logic [1:0]                i_pop_len,
  output logic [15:0]               o_rd0,
  output logic [15:0]               o_rd1,
  output logic [$clog2(BUF_HW):0]   o_count,
  output logic                      o_full
);

  localparam int unsigned PW = $clog2(BUF_HW);
  localparam int unsigned CW = PW + 1;

  logic [15:0]   r_mem [BUF_HW];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_wr;

  assign w_wr = i_push && !i_flush;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(i_pop_len);
      r_count <= r_count + CW'(i_push) - (i_pop ? CW'(i_pop_len) : CW'(0));
    end
  end

  // Storage needs no reset: reads are masked by the count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_tail] <= i_data;
  end

  assign o_rd0   = (r_count != CW'(0)) ? r_mem[r_head] : 16'h0000;
  assign o_rd1   = (r_count >= CW'(2)) ? r_mem[r_head + PW'(1)] : 16'h0000;
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(BUF_HW));

endmodule

// File: rtl/tinyqv_instr_aligner.sv
// Instruction prefetch/alignment buffer in front of the TinyQV decoder:
// tracks fetch and instruction PCs, handles redirects and the length check.
module tinyqv_instr_aligner
  import tinyqv_instr_aligner_pkg::*;
#(
  parameter int unsigned BUF_HW  = 4,
  parameter int unsigned PC_BITS = TQV_PC_BITS
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [15:0]        fetch_data,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  output logic [PC_BITS-1:0] fetch_addr,
  output logic               fetch_restart,
  input  logic               redirect,
  input  logic [PC_BITS-1:0] redirect_pc,
  output logic [31:0]        instr,
  output logic [PC_BITS-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               instr_consume,
  input  logic [1:0]         consume_len
);

  localparam int unsigned CW = $clog2(BUF_HW) + 1;

  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] r_fetch_addr;
  logic               r_restart;

  logic [15:0]   w_rd0;
  logic [15:0]   w_rd1;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_len_ok;
  logic          w_valid;
  instr_win_t    w_win;

  // Data arriving in the restart cycle belongs to the old stream.
  assign w_push   = fetch_valid && !w_full && !redirect && !r_restart;
  assign w_len_ok = ((consume_len == TQV_LEN_16) || (consume_len == TQV_LEN_32)) &&
                    (CW'(consume_len) <= w_count);
  assign w_pop    = instr_consume && w_valid && w_len_ok && !redirect;

  tinyqv_halfword_fifo #(
    .BUF_HW (BUF_HW)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_flush   (redirect),
    .i_push    (w_push),
    .i_data    (fetch_data),
    .i_pop     (w_pop),
    .i_pop_len (consume_len),
    .o_rd0     (w_rd0),
    .o_rd1     (w_rd1),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  // A lone head halfword is complete only if it is a compressed instruction.
  assign w_valid = (w_count >= CW'(2)) ||
                   ((w_count == CW'(1)) && (w_rd0[1:0] != TQV_RVC_OPCODE_32));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc         <= '0;
      r_fetch_addr <= '0;
      r_restart    <= 1'b1;
    end else if (redirect) begin
      r_pc         <= redirect_pc;
      r_fetch_addr <= redirect_pc;
      r_restart    <= 1'b1;
    end else begin
      r_restart <= 1'b0;
      if (w_push) r_fetch_addr <= r_fetch_addr + PC_BITS'(1);
      if (w_pop)  r_pc         <= r_pc + PC_BITS'(consume_len);
    end
  end

  assign w_win.lo      = w_rd0;
  assign w_win.hi      = w_rd1;
  assign instr         = w_win;
  assign instr_valid   = w_valid;
  assign instr_pc      = r_pc;
  assign fetch_addr    = r_fetch_addr;
  assign fetch_restart = r_restart;
  assign fetch_ready   = !w_full;

endmodule

// File: tb/tb_tinyqv_instr_aligner.sv
// Directed bench for tinyqv_instr_aligner with hand-computed expectations.
module tb_tinyqv_instr_aligner;

  logic        clk;
  logic        rstn;
  logic [15:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [22:0] fetch_addr;
  logic        fetch_restart;
  logic        redirect;
  logic [22:0] redirect_pc;
  logic [31:0] instr;
  logic [22:0] instr_pc;
  logic        instr_valid;
  logic        instr_consume;
  logic [1:0]  consume_len;

  int total = 0;
  int bad   = 0;

  tinyqv_instr_aligner dut (
    .clk           (clk),
    .rstn          (rstn),
    .fetch_data    (fetch_data),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_addr    (fetch_addr),
    .fetch_restart (fetch_restart),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_consume (instr_consume),
    .consume_len   (consume_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full visible state: valid, instr, pc, fetch_addr, ready, restart.
  task automatic chk_all(input string tag, input logic v, input logic [31:0] ins,
                         input logic [22:0] pc, input logic [22:0] fa,
                         input logic rdy, input logic rs);
    chk({tag, ".valid"},   32'(instr_valid),   32'(v));
    chk({tag, ".instr"},   instr,              ins);
    chk({tag, ".pc"},      32'(instr_pc),      32'(pc));
    chk({tag, ".faddr"},   32'(fetch_addr),    32'(fa));
    chk({tag, ".ready"},   32'(fetch_ready),   32'(rdy));
    chk({tag, ".restart"}, 32'(fetch_restart), 32'(rs));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid   = 1'b0;
    instr_consume = 1'b0;
    redirect      = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; fetch_data = '0; fetch_valid = 1'b0; redirect = 1'b0;
    redirect_pc = '0; instr_consume = 1'b0; consume_len = 2'b01;
    #12;
    chk_all("reset", 1'b0, 32'h0, 23'h0, 23'h0, 1'b1, 1'b1);
    @(negedge clk); rstn = 1'b1;
    step();
    chk_all("restart_done", 1'b0, 32'h0, 23'h0, 23'h0, 1'b1, 1'b0);

    // Compressed instruction valid on its own, then full window.
    fetch_valid = 1'b1; fetch_data = 16'h4501; step();
    chk_all("rvc_one", 1'b1, 32'h00004501, 23'h0, 23'h1, 1'b1, 1'b0);
    fetch_data = 16'h0513; step();
    chk_all("two_hw", 1'b1, 32'h05134501, 23'h0, 23'h2, 1'b1, 1'b0);
    fetch_valid = 1'b0; instr_consume = 1'b1; consume_len = 2'b01; step();
    chk_all("lone_32b", 1'b0, 32'h00000513, 23'h1, 23'h2, 1'b1, 1'b0);
    instr_consume = 1'b0; fetch_valid = 1'b1; fetch_data = 16'h0010; step();
    chk_all("full_32b", 1'b1, 32'h00100513, 23'h1, 23'h3, 1'b1, 1'b0);
    fetch_valid = 1'b0; instr_consume = 1'b1; consume_len = 2'b10; step();
    chk_all("pop2_empty", 1'b0, 32'h0, 23'h3, 23'h3, 1'b1, 1'b0);

    // Fill from buffer index 3; the head window straddles the wrap.
    instr_consume = 1'b0; fetch_valid = 1'b1;
    fetch_data = 16'h0001; step();
    fetch_data = 16'h0005; step();
    fetch_data = 16'h0009; step();
    fetch_data = 16'h000d; step();
    chk_all("full", 1'b1, 32'h00050001, 23'h3, 23'h7, 1'b0, 1'b0);
    fetch_data = 16'hdead; step();
    chk_all("full_drop", 1'b1, 32'h00050001, 23'h3, 23'h7, 1'b0, 1'b0);
    fetch_data = 16'hbeef; instr_consume = 1'b1; consume_len = 2'b01; step();
    chk_all("no_pop_credit", 1'b1, 32'h00090005, 23'h4, 23'h7, 1'b1, 1'b0);

    // Simultaneous push and two-halfword pop.
    fetch_data = 16'h0003; consume_len = 2'b10; step();
    chk_all("push_pop2", 1'b1, 32'h0003000d, 23'h6, 23'h8, 1'b1, 1'b0);
    fetch_valid = 1'b0; consume_len = 2'b01; step();
    chk_all("wait_hi", 1'b0, 32'h00000003, 23'h7, 23'h8, 1'b1, 1'b0);
    instr_consume = 1'b0; fetch_valid = 1'b1; fetch_data = 16'h1234; step();
    chk_all("wrap_32b", 1'b1, 32'h12340003, 23'h7, 23'h9, 1'b1, 1'b0);

    // Redirect wins over same-cycle push and consume.
    redirect = 1'b1; redirect_pc = 23'h000101; fetch_data = 16'h5555;
    instr_consume = 1'b1; consume_len = 2'b10; step();
    chk_all("redirect", 1'b0, 32'h0, 23'h000101, 23'h000101, 1'b1, 1'b1);
    redirect = 1'b0; instr_consume = 1'b0; fetch_data = 16'h6666; step();
    chk_all("restart_drop", 1'b0, 32'h0, 23'h000101, 23'h000101, 1'b1, 1'b0);
    fetch_data = 16'h4501; step();
    chk_all("new_stream", 1'b1, 32'h00004501, 23'h000101, 23'h000102, 1'b1, 1'b0);

    // Redirect inside a restart cycle re-arms; PCs wrap at the top.
    fetch_valid = 1'b0; redirect = 1'b1; redirect_pc = 23'h7fffff; step();
    chk_all("redir_top", 1'b0, 32'h0, 23'h7fffff, 23'h7fffff, 1'b1, 1'b1);
    step();
    chk_all("rearm", 1'b0, 32'h0, 23'h7fffff, 23'h7fffff, 1'b1, 1'b1);
    redirect = 1'b0; fetch_valid = 1'b1; fetch_data = 16'h0001; step();
    chk_all("rearm_drop", 1'b0, 32'h0, 23'h7fffff, 23'h7fffff, 1'b1, 1'b0);
    fetch_data = 16'h0002; step();
    chk_all("faddr_wrap", 1'b1, 32'h00000002, 23'h7fffff, 23'h0, 1'b1, 1'b0);
    fetch_valid = 1'b0; instr_consume = 1'b1; consume_len = 2'b01; step();
    chk_all("pc_wrap", 1'b0, 32'h0, 23'h0, 23'h0, 1'b1, 1'b0);

    // Async reset with three halfwords buffered.
    instr_consume = 1'b0; fetch_valid = 1'b1;
    fetch_data = 16'h0011; step();
    fetch_data = 16'h0022; step();
    fetch_data = 16'h0033; step();
    idle();
    chk_all("pre_reset", 1'b1, 32'h00220011, 23'h0, 23'h3, 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 23'h0, 23'h0, 1'b1, 1'b1);
    @(negedge clk); rstn = 1'b1;
    step();
    chk_all("post_reset", 1'b0, 32'h0, 23'h0, 23'h0, 1'b1, 1'b0);
    fetch_valid = 1'b1; fetch_data = 16'h4501; step();
    chk_all("resume", 1'b1, 32'h00004501, 23'h0, 23'h1, 1'b1, 1'b0);
    idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
